ram_bist_ctrl: RTL and testbench

- Built-in self-test initiator for the on-chip dual-port RAM.
- Drives the RAM's write port (wr_en/w_addr/w_data) and read port (rd_en/rd_addr), and checks rd_data against expected values.
- Runs a fixed 4-element March sequence; reports pass, or the first failing address and data.
- Sits between the RAM and the test/config logic.

---
 rtl/ram_bist_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// March BIST initiator for the dual-port RAM: w0(up) r0w1(up) r1w0(down) r0(up); 7*DEPTH busy cycles, then a one-cycle done.
// No backpressure: the RAM accepts one access per cycle, and start is ignored while a run is in flight.
module ram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter logic [DATA_W-1:0] PAT = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  localparam logic [DATA_W-1:0] PATB = ~PAT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE,
    M0_W,
    M1_RD,
    M1_CHK,
    M2_RD,
    M2_CHK,
    M3_RD,
    M3_CHK,
    FIN
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              pass_q, pass_nxt;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_nxt;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_nxt;
  logic [DATA_W-1:0] fail_got_q, fail_got_nxt;

  logic              chk_cycle;
  logic [DATA_W-1:0] exp_dat;
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      pass_q      <= pass_nxt;
      fail_addr_q <= fail_addr_nxt;
      fail_exp_q  <= fail_exp_nxt;
      fail_got_q  <= fail_got_nxt;
    end
  end

  // Expected read value for the element currently in its check cycle.
  always_comb begin
    chk_cycle = 1'b0;
    exp_dat   = '0;
    case (state)
      M1_CHK: begin
        chk_cycle = 1'b1;
        exp_dat   = PAT;
      end
      M2_CHK: begin
        chk_cycle = 1'b1;
        exp_dat   = PATB;
      end
      M3_CHK: begin
        chk_cycle = 1'b1;
        exp_dat   = PAT;
      end
      default: begin
        chk_cycle = 1'b0;
        exp_dat   = '0;
      end
    endcase
  end

  assign mismatch = chk_cycle && (ram_rd_data != exp_dat);

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    pass_nxt      = pass_q;
    fail_addr_nxt = fail_addr_q;
    fail_exp_nxt  = fail_exp_q;
    fail_got_nxt  = fail_got_q;
    ram_wr_en     = 1'b0;
    ram_w_addr    = '0;
    ram_w_data    = '0;
    ram_rd_en     = 1'b0;
    ram_rd_addr   = '0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = M0_W;
          addr_nxt      = '0;
          pass_nxt      = 1'b0;
          fail_addr_nxt = '0;
          fail_exp_nxt  = '0;
          fail_got_nxt  = '0;
        end
      end

      M0_W: begin
        busy       = 1'b1;
        ram_wr_en  = 1'b1;
        ram_w_addr = addr;
        ram_w_data = PAT;
        if (addr == LAST) begin
          addr_nxt  = '0;
          state_nxt = M1_RD;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end

      M1_RD, M2_RD, M3_RD: begin
        busy        = 1'b1;
        ram_rd_en   = 1'b1;
        ram_rd_addr = addr;
        case (state)
          M1_RD:   state_nxt = M1_CHK;
          M2_RD:   state_nxt = M2_CHK;
          default: state_nxt = M3_CHK;
        endcase
      end

      M1_CHK: begin
        busy = 1'b1;
        if (!mismatch) begin
          ram_wr_en  = 1'b1;
          ram_w_addr = addr;
          ram_w_data = PATB;
          if (addr == LAST) begin
            addr_nxt  = LAST;
            state_nxt = M2_RD;
          end else begin
            addr_nxt  = addr + 1'b1;
            state_nxt = M1_RD;
          end
        end
      end

      M2_CHK: begin
        busy = 1'b1;
        if (!mismatch) begin
          ram_wr_en  = 1'b1;
          ram_w_addr = addr;
          ram_w_data = PAT;
          if (addr == '0) begin
            addr_nxt  = '0;
            state_nxt = M3_RD;
          end else begin
            addr_nxt  = addr - 1'b1;
            state_nxt = M2_RD;
          end
        end
      end

      M3_CHK: begin
        busy = 1'b1;
        if (!mismatch) begin
          if (addr == LAST) begin
            addr_nxt  = '0;
            pass_nxt  = 1'b1;
            state_nxt = FIN;
          end else begin
            addr_nxt  = addr + 1'b1;
            state_nxt = M3_RD;
          end
        end
      end

      // Held start chains straight into the next run so back-to-back runs
      // are exactly 7*DEPTH+1 cycles apart.
      FIN: begin
        done     = 1'b1;
        addr_nxt = '0;
        if (start) begin
          state_nxt     = M0_W;
          pass_nxt      = 1'b0;
          fail_addr_nxt = '0;
          fail_exp_nxt  = '0;
          fail_got_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // First mismatch wins: capture it and abandon the run; the write above is
    // already suppressed for this cycle.
    if (mismatch) begin
      fail_addr_nxt = addr;
      fail_exp_nxt  = exp_dat;
      fail_got_nxt  = ram_rd_data;
      pass_nxt      = 1'b0;
      addr_nxt      = '0;
      state_nxt     = FIN;
    end
  end

  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: behavioural RAM with injectable faults,
// a table of fault scenarios, and hand sequences for reset and restart timing.
module tb_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ram_wr_en;
  logic [3:0] ram_w_addr;
  logic [7:0] ram_w_data;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rd_data;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_addr;
  logic [7:0] fail_exp;
  logic [7:0] fail_got;

  always #5 clk = ~clk;

  ram_bist_ctrl #(
    .ADDR_W(4),
    .DATA_W(8),
    .DEPTH (16),
    .PAT   (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ram_wr_en  (ram_wr_en),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_addr  (fail_addr),
    .fail_exp   (fail_exp),
    .fail_got   (fail_got)
  );

  // Behavioural RAM. fault_kind: 0 none, 1 stuck-at-1 on read, 2 stuck-at-0
  // on read, 3 writes to address 3 also land at fault_addr.
  logic [7:0] mem [16];
  int         fault_kind;
  logic [3:0] fault_addr;
  logic [7:0] fault_mask;

  function automatic logic [7:0] faulty(input logic [7:0] d, input logic [3:0] a);
    if (fault_kind == 1 && a == fault_addr) return d | fault_mask;
    if (fault_kind == 2 && a == fault_addr) return d & ~fault_mask;
    return d;
  endfunction

  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_w_addr] <= ram_w_data;
      if (fault_kind == 3 && ram_w_addr == 4'd3) mem[fault_addr] <= ram_w_data;
    end
    if (ram_rd_en) ram_rd_data <= faulty(mem[ram_rd_addr], ram_rd_addr);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [40:0] all_outs();
    return {busy, done, pass, fail_addr, fail_exp, fail_got,
            ram_wr_en, ram_w_addr, ram_w_data, ram_rd_en, ram_rd_addr};
  endfunction

  typedef struct {
    string      name;
    int         kind;
    logic [3:0] faddr;
    logic [7:0] fmask;
    int         exp_done;
    logic       exp_pass;
    logic [3:0] exp_faddr;
    logic [7:0] exp_fexp;
    logic [7:0] exp_fgot;
  } vec_t;

  vec_t vecs [4];

  // Per-run observations, collected once per cycle by observe().
  int done_cyc, busy_cnt, first_busy, overlap, m0_ok, wr_at_chk, busy_at_done;

  task automatic clear_obs();
    done_cyc = -1; busy_cnt = 0; first_busy = -1; overlap = 0;
    m0_ok = 0; wr_at_chk = -1; busy_at_done = -1;
  endtask

  task automatic observe(input int c, input int chk_cyc);
    if (busy) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = c;
    end
    if (ram_wr_en && ram_rd_en) overlap++;
    if (c >= 1 && c <= 16 && ram_wr_en && ram_w_addr == 4'(c - 1) && ram_w_data == 8'h00)
      m0_ok++;
    if (c == chk_cyc) wr_at_chk = int'(ram_wr_en);
    if (done && done_cyc < 0) begin
      done_cyc = c;
      busy_at_done = int'(busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Pulses start so that it is sampled at "edge 0"; returns #1 into cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  int   c;
  int   done1, done2, saw_done;
  logic pass_113, pass_114, busy_114, pass_226;

  initial begin
    vecs[0] = '{"clean",     0, 4'd0,  8'h00, 113, 1'b1, 4'd0,  8'h00, 8'h00};
    vecs[1] = '{"sa1_a5_b0", 1, 4'd5,  8'h01,  29, 1'b0, 4'd5,  8'h00, 8'h01};
    vecs[2] = '{"sa0_a12_b7",2, 4'd12, 8'h80,  57, 1'b0, 4'd12, 8'hFF, 8'h7F};
    vecs[3] = '{"alias_3_9", 3, 4'd9,  8'h00,  37, 1'b0, 4'd9,  8'h00, 8'hFF};

    fault_kind = 0; fault_addr = '0; fault_mask = '0;
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_with_start", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    start = 1'b0;

    for (int i = 0; i < 4; i++) begin
      fault_kind = vecs[i].kind;
      fault_addr = vecs[i].faddr;
      fault_mask = vecs[i].fmask;
      do_reset();
      pulse_start();
      clear_obs();
      for (int k = 1; k <= 300; k++) begin
        observe(k, vecs[i].exp_done - 1);
        if (done_cyc >= 0) break;
        @(posedge clk);
        #1;
      end
      check({vecs[i].name, ".done_cycle"}, 64'(done_cyc), 64'(vecs[i].exp_done));
      check({vecs[i].name, ".pass"}, 64'(pass), 64'(vecs[i].exp_pass));
      check({vecs[i].name, ".fail_addr"}, 64'(fail_addr), 64'(vecs[i].exp_faddr));
      check({vecs[i].name, ".fail_exp"}, 64'(fail_exp), 64'(vecs[i].exp_fexp));
      check({vecs[i].name, ".fail_got"}, 64'(fail_got), 64'(vecs[i].exp_fgot));
      check({vecs[i].name, ".busy_cycles"}, 64'(busy_cnt), 64'(vecs[i].exp_done - 1));
      check({vecs[i].name, ".first_busy"}, 64'(first_busy), 64'd1);
      check({vecs[i].name, ".busy_in_fin"}, 64'(busy_at_done), 64'd0);
      check({vecs[i].name, ".rd_wr_overlap"}, 64'(overlap), 64'd0);
      check({vecs[i].name, ".m0_writes"}, 64'(m0_ok), 64'd16);
      check({vecs[i].name, ".write_in_last_chk"}, 64'(wr_at_chk), 64'd0);
    end

    // Reset in the middle of a run: clean abort, then a full fresh run.
    fault_kind = 0;
    do_reset();
    pulse_start();
    saw_done = 0;
    for (c = 1; c < 40; c++) begin
      if (done) saw_done++;
      @(posedge clk);
      #1;
    end
    if (done) saw_done++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_rst.outputs", 64'(all_outs()), 64'd0);
    if (done) saw_done++;
    check("midrun_rst.no_done", 64'(saw_done), 64'd0);
    rst = 1'b0;
    pulse_start();
    clear_obs();
    for (int k = 1; k <= 300; k++) begin
      observe(k, 112);
      if (done_cyc >= 0) break;
      @(posedge clk);
      #1;
    end
    check("after_rst.done_cycle", 64'(done_cyc), 64'd113);
    check("after_rst.pass", 64'(pass), 64'd1);
    check("after_rst.busy_cycles", 64'(busy_cnt), 64'd112);

    // Stray start mid-run is ignored; start held from cycle 100 chains runs.
    do_reset();
    pulse_start();
    done1 = -1; done2 = -1;
    pass_113 = 1'b0; pass_114 = 1'b1; busy_114 = 1'b0; pass_226 = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (done) begin
        if (done1 < 0) begin
          done1 = k;
          pass_113 = pass;
        end else if (done2 < 0) begin
          done2 = k;
          pass_226 = pass;
        end
      end
      if (k == done1 + 1 && done1 > 0) begin
        busy_114 = busy;
        pass_114 = pass;
      end
      if (k == 50) start = 1'b1;
      if (k == 51) start = 1'b0;
      if (k == 100) start = 1'b1;
      if (done2 > 0) begin
        start = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("chain.done1_cycle", 64'(done1), 64'd113);
    check("chain.pass_run1", 64'(pass_113), 64'd1);
    check("chain.busy_after_fin", 64'(busy_114), 64'd1);
    check("chain.pass_cleared", 64'(pass_114), 64'd0);
    check("chain.done2_cycle", 64'(done2), 64'd226);
    check("chain.pass_run2", 64'(pass_226), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("chain.idle_busy", 64'(busy), 64'd0);
    check("chain.idle_pass_held", 64'(pass), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
